// File: rtl/gnn_result_collector.sv
// Collects the eight GNN output logits into a capture bank, swaps full frames into an emit bank,
// and streams one {node, logit0, logit1, argmax} record per node over valid/ready.
module gnn_result_collector #(
    parameter int DATA_WIDTH      = 21,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] out0_node0,
    input  logic signed [DATA_WIDTH-1:0] out0_node1,
    input  logic signed [DATA_WIDTH-1:0] out0_node2,
    input  logic signed [DATA_WIDTH-1:0] out0_node3,
    input  logic signed [DATA_WIDTH-1:0] out1_node0,
    input  logic signed [DATA_WIDTH-1:0] out1_node1,
    input  logic signed [DATA_WIDTH-1:0] out1_node2,
    input  logic signed [DATA_WIDTH-1:0] out1_node3,
    input  logic                         out10_ready_node0,
    input  logic                         out10_ready_node1,
    input  logic                         out10_ready_node2,
    input  logic                         out10_ready_node3,
    input  logic                         out11_ready_node0,
    input  logic                         out11_ready_node1,
    input  logic                         out11_ready_node2,
    input  logic                         out11_ready_node3,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [1:0]                   res_node,
    output logic signed [DATA_WIDTH-1:0] res_out0,
    output logic signed [DATA_WIDTH-1:0] res_out1,
    output logic                         res_class,
    output logic                         frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]   frame_count,
    output logic                         overrun
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // Slot 2*node + logit
    logic signed [DATA_WIDTH-1:0] w_in_dat [8];
    logic [7:0]                   w_flag;

    logic signed [DATA_WIDTH-1:0] r_cap_dat [8];
    logic signed [DATA_WIDTH-1:0] r_emt_dat [8];
    logic [7:0]                   r_cap_vld;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic                         w_cap_full;
    logic                         w_hs;
    logic                         w_last_hs;
    logic                         w_swap;
    logic                         w_load;
    logic [1:0]                   w_node_inc;
    logic [1:0]                   w_node_nxt;
    logic signed [DATA_WIDTH-1:0] w_src_o0;
    logic signed [DATA_WIDTH-1:0] w_src_o1;

    assign w_in_dat[0] = out0_node0;
    assign w_in_dat[1] = out1_node0;
    assign w_in_dat[2] = out0_node1;
    assign w_in_dat[3] = out1_node1;
    assign w_in_dat[4] = out0_node2;
    assign w_in_dat[5] = out1_node2;
    assign w_in_dat[6] = out0_node3;
    assign w_in_dat[7] = out1_node3;

    assign w_flag = {out11_ready_node3, out10_ready_node3,
                     out11_ready_node2, out10_ready_node2,
                     out11_ready_node1, out10_ready_node1,
                     out11_ready_node0, out10_ready_node0};

    assign res_valid  = (r_state == S_SEND);
    assign w_cap_full = &r_cap_vld;
    assign w_hs       = res_valid && res_ready;
    assign w_last_hs  = w_hs && (res_node == 2'd3);
    // A full bank moves to emit as soon as the emitter is idle or finishing its last record
    assign w_swap     = w_cap_full && ((r_state == S_IDLE) || w_last_hs);
    assign w_node_inc = res_node + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_swap) w_state_nxt = S_SEND;
            S_SEND:  if (w_last_hs && !w_swap) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // On a swap the first record comes straight from the bank being handed over
    always_comb begin
        w_load     = 1'b0;
        w_node_nxt = res_node;
        w_src_o0   = r_emt_dat[0];
        w_src_o1   = r_emt_dat[1];
        if (w_swap) begin
            w_load     = 1'b1;
            w_node_nxt = 2'd0;
            w_src_o0   = r_cap_dat[0];
            w_src_o1   = r_cap_dat[1];
        end else if (w_hs && !w_last_hs) begin
            w_load     = 1'b1;
            w_node_nxt = w_node_inc;
            w_src_o0   = r_emt_dat[{w_node_inc, 1'b0}];
            w_src_o1   = r_emt_dat[{w_node_inc, 1'b1}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_node    <= 2'd0;
            res_out0    <= '0;
            res_out1    <= '0;
            res_class   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
            r_cap_vld   <= '0;
        end else begin
            frame_done <= w_last_hs;
            if (w_last_hs)
                frame_count <= frame_count + 1'b1;
            if (|(w_flag & r_cap_vld))
                overrun <= 1'b1;
            if (w_load) begin
                res_node  <= w_node_nxt;
                res_out0  <= w_src_o0;
                res_out1  <= w_src_o1;
                res_class <= (w_src_o1 > w_src_o0);
            end
            if (w_swap) r_cap_vld <= '0;
            else        r_cap_vld <= r_cap_vld | w_flag;
        end
    end

    // Filled slots are write-protected, so flags in the swap cycle never corrupt the outgoing bank
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (w_flag[i] && !r_cap_vld[i])
                r_cap_dat[i] <= w_in_dat[i];
        end
        if (w_swap)
            r_emt_dat <= r_cap_dat;
    end

endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed bench for gnn_result_collector: table of per-node records plus
// hand-written backpressure, overlap, overrun and mid-emit reset sequences.
module tb_gnn_result_collector;
    localparam int DW = 21;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [3:0][DW-1:0]   o0, o1;
    logic [3:0]           f0, f1;
    logic                 res_ready;
    logic                 res_valid;
    logic [1:0]           res_node;
    logic signed [DW-1:0] res_out0, res_out1;
    logic                 res_class;
    logic                 frame_done;
    logic [CW-1:0]        frame_count;
    logic                 overrun;

    gnn_result_collector #(.DATA_WIDTH(DW), .FRAME_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
        .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
        .out10_ready_node0(f0[0]), .out10_ready_node1(f0[1]),
        .out10_ready_node2(f0[2]), .out10_ready_node3(f0[3]),
        .out11_ready_node0(f1[0]), .out11_ready_node1(f1[1]),
        .out11_ready_node2(f1[2]), .out11_ready_node3(f1[3]),
        .res_valid(res_valid), .res_ready(res_ready), .res_node(res_node),
        .res_out0(res_out0), .res_out1(res_out1), .res_class(res_class),
        .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun)
    );

    typedef struct {
        logic signed [DW-1:0] o0;
        logic signed [DW-1:0] o1;
        logic                 cls;
    } rec_t;

    rec_t tbl [16];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    function automatic rec_t mk(input int a, input int b, input bit c);
        rec_t r;
        r.o0  = a[DW-1:0];
        r.o1  = b[DW-1:0];
        r.cls = c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_frame(input int f);
        for (int k = 0; k < 4; k++) begin
            o0[k] = tbl[4*f+k].o0;
            o1[k] = tbl[4*f+k].o1;
        end
    endtask

    task automatic send_frame(input int f);
        load_frame(f);
        f0 = 4'hF;
        f1 = 4'hF;
        tick();
        f0 = 4'h0;
        f1 = 4'h0;
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!res_valid && w < 20) begin
            tick();
            w++;
        end
        chk("valid_timeout", int'(res_valid), 1);
    endtask

    // Expects res_ready=1; consumes records k0..3 of table frame f
    task automatic recv_frame(input int f, input int k0);
        wait_valid();
        for (int k = k0; k < 4; k++) begin
            chk($sformatf("f%0d_n%0d_valid", f, k), int'(res_valid), 1);
            chk($sformatf("f%0d_n%0d_node", f, k), int'(res_node), k);
            chk($sformatf("f%0d_n%0d_out0", f, k), int'(res_out0), int'(tbl[4*f+k].o0));
            chk($sformatf("f%0d_n%0d_out1", f, k), int'(res_out1), int'(tbl[4*f+k].o1));
            chk($sformatf("f%0d_n%0d_class", f, k), int'(res_class), int'(tbl[4*f+k].cls));
            tick();
        end
        exp_cnt++;
        chk($sformatf("f%0d_frame_done", f), int'(frame_done), 1);
        chk($sformatf("f%0d_frame_count", f), int'(frame_count), exp_cnt);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_node"}, int'(res_node), 0);
        chk({tag, "_out0"}, int'(res_out0), 0);
        chk({tag, "_out1"}, int'(res_out1), 0);
        chk({tag, "_class"}, int'(res_class), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_count"}, int'(frame_count), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        // frame 0: node k = (10k, 10k+5)
        tbl[0]  = mk(0, 5, 1);          tbl[1]  = mk(10, 15, 1);
        tbl[2]  = mk(20, 25, 1);        tbl[3]  = mk(30, 35, 1);
        // frame 1: sign and tie cases, extremes of 21-bit range
        tbl[4]  = mk(-3, -5, 0);        tbl[5]  = mk(-5, -3, 1);
        tbl[6]  = mk(7, 7, 0);          tbl[7]  = mk(1048575, -1048576, 0);
        // frame 2: mixed
        tbl[8]  = mk(-1, 0, 1);         tbl[9]  = mk(100, -100, 0);
        tbl[10] = mk(-1048576, 1048575, 1); tbl[11] = mk(0, 0, 0);
        // frame 3: overrun frame, node2 logit0 keeps the first value 4
        tbl[12] = mk(0, 5, 1);          tbl[13] = mk(10, 15, 1);
        tbl[14] = mk(4, 25, 1);         tbl[15] = mk(30, 35, 1);

        rst = 1'b1; f0 = '0; f1 = '0; o0 = '0; o1 = '0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("rst");

        // single frame with latency check
        res_ready = 1'b1;
        send_frame(0);
        chk("lat_edge_n", int'(res_valid), 0);
        tick();
        chk("lat_edge_n1", int'(res_valid), 1);
        recv_frame(0, 0);
        tick();
        chk("frame_done_pulse", int'(frame_done), 0);
        chk("idle_valid", int'(res_valid), 0);

        for (int f = 1; f < 3; f++) begin
            send_frame(f);
            recv_frame(f, 0);
            tick();
        end

        // backpressure on node 1
        send_frame(2);
        wait_valid();
        chk("bp_node0", int'(res_node), 0);
        tick();
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_node", int'(res_node), 1);
            chk("bp_hold_out0", int'(res_out0), int'(tbl[9].o0));
            chk("bp_hold_out1", int'(res_out1), int'(tbl[9].o1));
            chk("bp_hold_valid", int'(res_valid), 1);
            chk("bp_hold_count", int'(frame_count), exp_cnt);
            tick();
        end
        res_ready = 1'b1;
        recv_frame(2, 1);
        tick();

        // overlap: B captured while A stalled
        res_ready = 1'b0;
        send_frame(0);
        wait_valid();
        send_frame(1);
        repeat (3) tick();
        chk("ovl_hold_node", int'(res_node), 0);
        chk("ovl_hold_out0", int'(res_out0), int'(tbl[0].o0));
        res_ready = 1'b1;
        recv_frame(0, 0);
        chk("ovl_no_bubble_valid", int'(res_valid), 1);
        chk("ovl_no_bubble_node", int'(res_node), 0);
        recv_frame(1, 0);
        tick();

        // overrun: node2 logit0 flag held two cycles
        chk("ovr_before", int'(overrun), 0);
        load_frame(3);
        f0 = 4'hF; f1 = 4'hF;
        tick();
        f0 = 4'b0100; f1 = 4'h0; o0[2] = 21'd9;
        tick();
        f0 = 4'h0;
        chk("ovr_set", int'(overrun), 1);
        recv_frame(3, 0);
        tick();
        send_frame(1);
        recv_frame(1, 0);
        chk("ovr_sticky", int'(overrun), 1);
        tick();

        // reset during node 2 record
        send_frame(0);
        wait_valid();
        tick(); tick();
        chk("mid_node2", int'(res_node), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("midrst");
        tick();
        chk("midrst_no_done", int'(frame_done), 0);
        chk("midrst_idle", int'(res_valid), 0);
        exp_cnt = 0;
        send_frame(1);
        recv_frame(1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
